vga_rx: RTL

Receive-side VGA timing decoder: the sink end of the `vga_ctrl` sync/RGB interface. It samples `hsync`, `vsync` and 16-bit RGB565 on `vga_clk` and rebuilds pixel coordinates, a data-valid strobe and a frame-start pulse. It checks line and frame lengths against the 640x480@60 timing and reports lock. It sits downstream of a VGA source, either a loopback of `vga_ctrl` outputs or an external source already synchronous to `vga_clk`, and feeds capture/analysis logic.

---
 rtl/vga_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx.sv
// vga_rx: receive-side VGA timing decoder.
// Samples hsync/vsync/RGB565 on vga_clk and rebuilds the pixel coordinates,
// a pixel-valid strobe and a frame-start pulse. It checks every line and
// frame against the nominal timing and reports lock.
// The optional error counter (err_cnt) is built only when the macro
// VGA_RX_STATS_EN is defined. Otherwise err_cnt is tied to zero.
// Latency from pin to every output is two clocks: one input register, then
// one output register.

module vga_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACT_START = 144,
  parameter int H_VALID     = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_START = 35,
  parameter int V_VALID     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] CNT_MAX = '1;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_WIN_LO = 10'(H_ACT_START);
  localparam logic [9:0] H_WIN_HI = 10'(H_ACT_START + H_VALID);
  localparam logic [9:0] V_WIN_LO = 10'(V_ACT_START);
  localparam logic [9:0] V_WIN_HI = 10'(V_ACT_START + V_VALID);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state;
  logic [7:0]  good_cnt;
  logic        hs_r, hs_rr, vs_r, vs_last, bad_seen;
  logic [15:0] rgb_r;
  logic [9:0]  h_cnt, v_cnt;

  logic        line_ev, frame_ev, line_good, frame_good, timeout;
  logic        line_fail, frame_fail, lock_next, in_win;
  logic [9:0]  h_cur, v_cur;
  logic [7:0]  cnt_inc;

  // Input stage: register the pins once. hs_rr holds the previous sample
  // and is used for rising-edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_r  <= 1'b0;
      hs_rr <= 1'b0;
      vs_r  <= 1'b0;
      rgb_r <= '0;
    end else begin
      hs_r  <= hsync;
      hs_rr <= hs_r;
      vs_r  <= vsync;
      rgb_r <= rgb;
    end
  end

  // Event decode, counter look-ahead, line/frame checks and next-lock decision.
  // h_cur/v_cur are the coordinates of the pin cycle now sitting in the input stage.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    line_ev    = 1'b0;
    frame_ev   = 1'b0;
    h_cur      = '0;
    v_cur      = '0;
    line_good  = 1'b0;
    frame_good = 1'b0;
    timeout    = 1'b0;
    line_fail  = 1'b0;
    frame_fail = 1'b0;
    cnt_inc    = '0;
    lock_next  = 1'b0;
    in_win     = 1'b0;

    line_ev  = hs_r & ~hs_rr;
    frame_ev = line_ev & vs_r & ~vs_last;

    if (line_ev)                h_cur = '0;
    else if (h_cnt == CNT_MAX)  h_cur = CNT_MAX;
    else                        h_cur = h_cnt + 10'd1;

    if (frame_ev)               v_cur = '0;
    else if (line_ev)           v_cur = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 10'd1;
    else                        v_cur = v_cnt;

    // h_cnt still holds the last h value of the line that just ended.
    line_good  = (h_cnt == H_LAST);
    frame_good = line_good && !bad_seen && (v_cnt == V_LAST);
    timeout    = !line_ev && (h_cur == CNT_MAX);
    line_fail  = line_ev & ~line_good;
    frame_fail = frame_ev & ~frame_good;
    cnt_inc    = good_cnt + 8'd1;

    case (state)
      LOCKED:  lock_next = !(timeout || line_fail || frame_fail);
      CHECK:   lock_next = frame_ev && frame_good && (cnt_inc == LOCK_N);
      default: lock_next = 1'b0;
    endcase

    in_win = (h_cur >= H_WIN_LO) && (h_cur < H_WIN_HI) &&
             (v_cur >= V_WIN_LO) && (v_cur < V_WIN_HI);
  end

  // Horizontal and vertical counters, plus the per-frame bad-line tracker.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      vs_last  <= 1'b0;
      bad_seen <= 1'b0;
    end else begin
      h_cnt <= h_cur;
      v_cnt <= v_cur;
      if (line_ev) vs_last <= vs_r;
      // The line ending at a frame event is already folded into frame_good.
      if (frame_ev)       bad_seen <= 1'b0;
      else if (line_fail) bad_seen <= 1'b1;
    end
  end

  // Lock FSM with registered locked/frame_start outputs.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= SEARCH;
      good_cnt    <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      locked      <= lock_next;
      frame_start <= frame_ev & lock_next;
      case (state)
        SEARCH: begin
          // The partial frame seen before this event is never counted.
          if (frame_ev) begin
            state    <= CHECK;
            good_cnt <= '0;
          end
        end
        CHECK: begin
          if (timeout) begin
            state <= SEARCH;
          end else if (frame_ev && frame_good) begin
            good_cnt <= cnt_inc;
            if (cnt_inc == LOCK_N) state <= LOCKED;
          end else if (line_fail || frame_fail) begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (!lock_next) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef VGA_RX_STATS_EN
  // Count lock losses. This is a single increment per event and saturates at 255.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                          err_cnt <= '0;
    else if (state == LOCKED && !lock_next && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

  // Pixel outputs. These are zero unless the decoder is locked and inside the active window.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
    end else if (lock_next && in_win) begin
      pix_valid <= 1'b1;
      pix_x     <= h_cur - H_WIN_LO;
      pix_y     <= v_cur - V_WIN_LO;
      pix_data  <= rgb_r;
    end else begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
    end
  end

endmodule
